// File: rtl/getreg_lookup_if.sv
// getreg_lookup_if
//   Request/response bundle for the register-index to ABI-name translator.
//   master : drives idx_valid/idx, receives name_valid/name/idx_err
//   slave  : the lookup block, the mirror image of master
//   NAME_W : width of the packed ASCII name (right-justified, upper bits zero)
//   IDX_W  : width of the register index (must be greater than 5)
interface getreg_lookup_if #(
  parameter int NAME_W = 33,
  parameter int IDX_W  = 6
);
  logic              idx_valid;
  logic [IDX_W-1:0]  idx;
  logic              name_valid;
  logic [NAME_W-1:0] name;
  logic              idx_err;

  modport master (
    output idx_valid, idx,
    input  name_valid, name, idx_err
  );

  modport slave (
    input  idx_valid, idx,
    output name_valid, name, idx_err
  );
endinterface

// File: rtl/getreg_lookup.sv
// getreg_lookup
//   Translates a GPR index (x0..x31) into its packed ASCII ABI mnemonic for the
//   debug/trace path. There is one registered stage, so a request is answered
//   exactly one cycle later. Requests may arrive every cycle.
// Ports
//   clk   : system clock, all state on posedge
//   reset : synchronous, active-high; wins over a simultaneous request
//   bus   : slave side of getreg_lookup_if
//           idx_valid/idx in, name_valid/name/idx_err out
//   name_valid pulses for one cycle per accepted request. name/idx_err hold
//   their last values while no request is accepted.
module getreg_lookup #(
  parameter int NAME_W = 33,
  parameter int IDX_W  = 6
) (
  input  logic           clk,
  input  logic           reset,
  getreg_lookup_if.slave bus
);

  // "inv" is returned for any index with a bit set above bit 4.
  localparam logic [31:0] INV_NAME = 32'h0069_6e76;

  // ABI mnemonic ROM. Each entry is right-justified ASCII with zero fill.
  function automatic logic [31:0] abi_name(input logic [4:0] r);
    logic [31:0] n;
    n = '0;
    case (r)
      5'd0:  n = 32'h7a65_726f; // zero
      5'd1:  n = 32'h0000_7261; // ra
      5'd2:  n = 32'h0000_7370; // sp
      5'd3:  n = 32'h0000_6770; // gp
      5'd4:  n = 32'h0000_7470; // tp
      5'd5:  n = 32'h0000_7430; // t0
      5'd6:  n = 32'h0000_7431; // t1
      5'd7:  n = 32'h0000_7432; // t2
      5'd8:  n = 32'h0000_7330; // s0 (the trace never prints "fp")
      5'd9:  n = 32'h0000_7331; // s1
      5'd10: n = 32'h0000_6130; // a0
      5'd11: n = 32'h0000_6131; // a1
      5'd12: n = 32'h0000_6132; // a2
      5'd13: n = 32'h0000_6133; // a3
      5'd14: n = 32'h0000_6134; // a4
      5'd15: n = 32'h0000_6135; // a5
      5'd16: n = 32'h0000_6136; // a6
      5'd17: n = 32'h0000_6137; // a7
      5'd18: n = 32'h0000_7332; // s2
      5'd19: n = 32'h0000_7333; // s3
      5'd20: n = 32'h0000_7334; // s4
      5'd21: n = 32'h0000_7335; // s5
      5'd22: n = 32'h0000_7336; // s6
      5'd23: n = 32'h0000_7337; // s7
      5'd24: n = 32'h0000_7338; // s8
      5'd25: n = 32'h0000_7339; // s9
      5'd26: n = 32'h0073_3130; // s10
      5'd27: n = 32'h0073_3131; // s11
      5'd28: n = 32'h0000_7433; // t3
      5'd29: n = 32'h0000_7434; // t4
      5'd30: n = 32'h0000_7435; // t5
      5'd31: n = 32'h0000_7436; // t6
      default: n = '0;
    endcase
    return n;
  endfunction

  logic              name_valid_d, name_valid_q;
  logic [NAME_W-1:0] name_d,       name_q;
  logic              idx_err_d,    idx_err_q;
  logic              out_of_range;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    name_valid_d = idx_valid_in();
    name_d       = name_q;
    idx_err_d    = idx_err_q;
    out_of_range = |bus.idx[IDX_W-1:5];
    if (bus.idx_valid) begin
      idx_err_d = out_of_range;
      name_d    = out_of_range ? NAME_W'(INV_NAME) : NAME_W'(abi_name(bus.idx[4:0]));
    end
  end

  function automatic logic idx_valid_in();
    return bus.idx_valid;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      name_valid_q <= 1'b0;
      name_q       <= '0;
      idx_err_q    <= 1'b0;
    end else begin
      name_valid_q <= name_valid_d;
      name_q       <= name_d;
      idx_err_q    <= idx_err_d;
    end
  end

  assign bus.name_valid = name_valid_q;
  assign bus.name       = name_q;
  assign bus.idx_err    = idx_err_q;

endmodule

// File: tb/tb_getreg_lookup.sv
// tb_getreg_lookup
//   Directed and randomized bench for getreg_lookup. Expected outputs come
//   from a table of ABI names held as text and packed into ASCII here.
module tb_getreg_lookup;

  localparam int NAME_W = 33;
  localparam int IDX_W  = 6;

  logic clk;
  logic reset;

  getreg_lookup_if #(.NAME_W(NAME_W), .IDX_W(IDX_W)) bus ();

  getreg_lookup #(.NAME_W(NAME_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string abi [32] = '{
    "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
    "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
    "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
    "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
  };

  int passes = 0;
  int total  = 0;

  // Reference state: what the outputs must show after the current edge.
  logic              exp_valid;
  logic [NAME_W-1:0] exp_name;
  logic              exp_err;

  function automatic logic [NAME_W-1:0] ref_name(input int i);
    string s;
    logic [NAME_W-1:0] v;
    v = '0;
    s = (i >= 32) ? "inv" : abi[i];
    for (int k = 0; k < s.len(); k++) v = (v << 8) | NAME_W'(s[k]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One cycle: drive on the falling edge, let the rising edge act, then
  // compare all three outputs against the reference.
  task automatic step(input logic rst, input logic v, input int i, input string tag);
    @(negedge clk);
    reset         = rst;
    bus.idx_valid = v;
    bus.idx       = IDX_W'(i);
    @(posedge clk);
    if (rst) begin
      exp_valid = 1'b0;
      exp_name  = '0;
      exp_err   = 1'b0;
    end else if (v) begin
      exp_valid = 1'b1;
      exp_name  = ref_name(i);
      exp_err   = (i >= 32);
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check({tag, ".valid"}, 64'(bus.name_valid), 64'(exp_valid));
    check({tag, ".name"},  64'(bus.name),       64'(exp_name));
    check({tag, ".err"},   64'(bus.idx_err),    64'(exp_err));
  endtask

  initial begin
    reset         = 1'b1;
    bus.idx_valid = 1'b1;
    bus.idx       = '0;
    exp_valid     = 1'b0;
    exp_name      = '0;
    exp_err       = 1'b0;

    // Reset held with a live request: outputs stay at reset values.
    step(1'b1, 1'b1, 1, "rst0");
    step(1'b1, 1'b1, 1, "rst1");

    // Back-to-back first requests.
    step(1'b0, 1'b1, 0, "zero");
    step(1'b0, 1'b1, 1, "ra");
    check("zero_const", 64'(ref_name(0)), 64'h7a65726f);
    check("s10_const",  64'(ref_name(26)), 64'h733130);

    // Full sweep.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, i, $sformatf("sweep%0d", i));

    // Out of range.
    step(1'b0, 1'b1, 32, "inv32");
    step(1'b0, 1'b1, 63, "inv63");

    // Single request, then idle: name holds.
    step(1'b0, 1'b1, 10, "a0");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, $sformatf("hold%0d", i));

    // Reset on the same edge as a request for sp.
    step(1'b1, 1'b1, 2, "rst_sp");
    step(1'b0, 1'b0, 2, "after_rst");

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 63)), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
